// File: rtl/uart_receiver_if.sv
// Handshake bundle between the serial line / consumer and the UART receiver.
// The master side drives rx and go and observes the received byte and status.
interface uart_receiver_if;
    logic       rx;
    logic       go;
    logic [7:0] data;
    logic       dr;
    logic       ferr;

    modport master (output rx, go, input data, dr, ferr);
    modport slave  (input rx, go, output data, dr, ferr);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver clocked on the falling edge of clk; samples each bit once at
// its centre and holds the byte until the consumer acknowledges by dropping go.
module uart_receiver #(
    parameter int unsigned ClockFrequencyHz = 66_000_000,
    parameter int unsigned BaudRate         = 9600
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_receiver_if.slave bus
);

    localparam int unsigned BitTime  = ClockFrequencyHz / BaudRate;
    localparam int unsigned HalfBit  = BitTime / 2;
    localparam int unsigned CntW     = ($clog2(BitTime) > 1) ? $clog2(BitTime) : 1;
    localparam logic [CntW-1:0] BitLoad  = CntW'(BitTime - 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'(HalfBit - 1);

    typedef enum logic [2:0] {
        Idle,
        StartBit,
        DataBits,
        StopBit,
        WaitForGoLow
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [2:0]      idx;
    logic [7:0]      shift;
    logic [7:0]      data_q;
    logic            dr_q;
    logic            ferr_q;
    logic            rx_m;
    logic            rx_s;
    logic            rx_p;

    assign bus.data = data_q;
    assign bus.dr   = dr_q;
    assign bus.ferr = ferr_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= Idle;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            data_q <= '0;
            dr_q   <= 1'b0;
            ferr_q <= 1'b0;
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_p   <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            rx_p <= rx_s;

            case (state)
                Idle: begin
                    // Only a fresh high-to-low transition starts a frame.
                    if (bus.go && rx_p && !rx_s) begin
                        cnt   <= HalfLoad;
                        state <= StartBit;
                    end
                end
                StartBit: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            cnt   <= BitLoad;
                            idx   <= '0;
                            state <= DataBits;
                        end else begin
                            state <= Idle;
                        end
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                DataBits: begin
                    if (cnt == '0) begin
                        shift[idx] <= rx_s;
                        cnt        <= BitLoad;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= StopBit;
                        end
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StopBit: begin
                    if (cnt == '0) begin
                        data_q <= shift;
                        ferr_q <= ~rx_s;
                        dr_q   <= 1'b1;
                        state  <= WaitForGoLow;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                WaitForGoLow: begin
                    if (!bus.go) begin
                        dr_q  <= 1'b0;
                        state <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at BIT_TIME=10: frames are generated from a bit-level
// line model and the received byte/status are compared with what was sent.
module tb_uart_receiver;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] exp_data;

    uart_receiver_if bus ();

    uart_receiver #(
        .ClockFrequencyHz(20),
        .BaudRate        (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line level at clk cycle c of a 100-cycle 8N1 frame, 10 cycles per bit.
    function automatic logic frame_level(input logic [7:0] b, input logic stop, input int c);
        if (c < 10) return 1'b0;
        if (c < 90) return b[(c - 10) / 10];
        if (c < 100) return stop;
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            bus.rx = 1'b1;
        end
    endtask

    // Plays one frame; rise is the first frame cycle at which dr is seen high.
    task automatic play(input logic [7:0] b, input logic stop, input int rst_at,
                        input int go_off_at, output int rise,
                        output logic [7:0] rd_data, output logic rd_dr, output logic rd_ferr);
        rise    = -1;
        rd_data = '1;
        rd_dr   = 1'b1;
        rd_ferr = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            bus.rx = frame_level(b, stop, c);
            if (c == go_off_at) bus.go = 1'b0;
            #1;
            if (bus.dr === 1'b1 && rise < 0) rise = c;
            if (c == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                rd_data = bus.data;
                rd_dr   = bus.dr;
                rd_ferr = bus.ferr;
                #1 rst_n = 1'b1;
            end
        end
    endtask

    task automatic ack(output logic dr_after);
        @(posedge clk);
        bus.rx = 1'b1;
        bus.go = 1'b0;
        @(posedge clk);
        #1 dr_after = bus.dr;
        bus.go = 1'b1;
    endtask

    task automatic test_reset;
        bus.rx = 1'b1;
        bus.go = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.data !== 8'h00 || bus.dr !== 1'b0 || bus.ferr !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: data=%h dr=%b ferr=%b required 00 0 0", bus.data, bus.dr, bus.ferr);
        end
        @(posedge clk);
        rst_n = 1'b1;
        exp_data = 8'h00;
        idle(5);
    endtask

    task automatic test_basic;
        int rise; logic [7:0] d; logic r, f, dra;
        bus.go = 1'b1;
        idle(3);
        play(8'hA5, 1'b1, -1, -1, rise, d, r, f);
        checks++;
        if (rise < 90 || rise > 99) begin
            failures++;
            $display("FAIL a5_dr_rise: cycle=%0d required 90..99", rise);
        end
        checks++;
        if (bus.data !== 8'hA5 || bus.ferr !== 1'b0) begin
            failures++;
            $display("FAIL a5_data: data=%h ferr=%b required a5 0", bus.data, bus.ferr);
        end
        ack(dra);
        checks++;
        if (dra !== 1'b0) begin
            failures++;
            $display("FAIL a5_ack: dr=%b required 0", dra);
        end
        exp_data = 8'hA5;
        idle(4);
    endtask

    task automatic test_glitch;
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            bus.rx = (c < 3) ? 1'b0 : 1'b1;
            #1;
            if (bus.dr !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.data !== exp_data) begin
            failures++;
            $display("FAIL glitch: dr_seen=%b data=%h required 0 %h", seen, bus.data, exp_data);
        end
    endtask

    task automatic test_framing_error;
        int rise; logic [7:0] d; logic r, f, dra;
        play(8'h3C, 1'b0, -1, -1, rise, d, r, f);
        checks++;
        if (bus.dr !== 1'b1 || bus.data !== 8'h3C || bus.ferr !== 1'b1) begin
            failures++;
            $display("FAIL ferr_frame: dr=%b data=%h ferr=%b required 1 3c 1", bus.dr, bus.data, bus.ferr);
        end
        ack(dra);
        exp_data = 8'h3C;
        idle(4);
    endtask

    task automatic test_overrun;
        int rise; logic [7:0] d; logic r, f, dra;
        play(8'h11, 1'b1, -1, -1, rise, d, r, f);
        checks++;
        if (bus.data !== 8'h11) begin
            failures++;
            $display("FAIL overrun_first: data=%h required 11", bus.data);
        end
        idle(5);
        play(8'h22, 1'b1, -1, -1, rise, d, r, f);
        checks++;
        if (bus.data !== 8'h11 || bus.dr !== 1'b1) begin
            failures++;
            $display("FAIL overrun_lost: data=%h dr=%b required 11 1", bus.data, bus.dr);
        end
        ack(dra);
        idle(5);
        play(8'h22, 1'b1, -1, -1, rise, d, r, f);
        checks++;
        if (bus.data !== 8'h22 || bus.dr !== 1'b1) begin
            failures++;
            $display("FAIL overrun_resend: data=%h dr=%b required 22 1", bus.data, bus.dr);
        end
        ack(dra);
        exp_data = 8'h22;
        idle(4);
    endtask

    task automatic test_go_low_frame;
        int rise; logic [7:0] d; logic r, f;
        bus.go = 1'b0;
        idle(3);
        play(8'h81, 1'b1, -1, -1, rise, d, r, f);
        idle(5);
        checks++;
        if (rise != -1 || bus.data !== exp_data) begin
            failures++;
            $display("FAIL go_low_frame: rise=%0d data=%h required -1 %h", rise, bus.data, exp_data);
        end
        bus.go = 1'b1;
        idle(3);
    endtask

    task automatic test_go_drop_mid;
        int rise; logic [7:0] d, b; logic r, f;
        b = 8'($urandom);
        play(b, 1'b1, -1, 45, rise, d, r, f);
        idle(2);
        checks++;
        if (rise < 90 || rise > 99 || bus.data !== b || bus.dr !== 1'b0) begin
            failures++;
            $display("FAIL go_drop_mid: rise=%0d data=%h dr=%b required 90..99 %h 0", rise, bus.data, bus.dr, b);
        end
        exp_data = b;
        bus.go = 1'b1;
        idle(3);
    endtask

    task automatic test_reset_mid_frame;
        int rise; logic [7:0] d; logic r, f, dra;
        play(8'hC3, 1'b0, -1, -1, rise, d, r, f);
        ack(dra);
        idle(4);
        play(8'hFF, 1'b1, 55, -1, rise, d, r, f);
        checks++;
        if (d !== 8'h00 || r !== 1'b0 || f !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: data=%h dr=%b ferr=%b required 00 0 0", d, r, f);
        end
        idle(10);
        checks++;
        if (rise != -1 || bus.dr !== 1'b0 || bus.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_discard: rise=%0d dr=%b data=%h required -1 0 00", rise, bus.dr, bus.data);
        end
        play(8'h5A, 1'b1, -1, -1, rise, d, r, f);
        checks++;
        if (bus.dr !== 1'b1 || bus.data !== 8'h5A || bus.ferr !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_next: dr=%b data=%h ferr=%b required 1 5a 0", bus.dr, bus.data, bus.ferr);
        end
        ack(dra);
        exp_data = 8'h5A;
        idle(4);
    endtask

    task automatic test_random;
        int rise; logic [7:0] d, b; logic r, f, stop, dra;
        for (int n = 0; n < 10; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            play(b, stop, -1, -1, rise, d, r, f);
            checks++;
            if (rise < 90 || rise > 99 || bus.data !== b || bus.ferr !== ~stop) begin
                failures++;
                $display("FAIL random_%0d: rise=%0d data=%h ferr=%b required 90..99 %h %b",
                         n, rise, bus.data, bus.ferr, b, ~stop);
            end
            ack(dra);
            checks++;
            if (dra !== 1'b0) begin
                failures++;
                $display("FAIL random_ack_%0d: dr=%b required 0", n, dra);
            end
            exp_data = b;
            idle($urandom_range(1, 15));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_framing_error;
        test_overrun;
        test_go_low_frame;
        test_go_drop_mid;
        test_reset_mid_frame;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter ClockFrequencyHz, default 66_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 9600, meaning the serial bit rate.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state SHALL update on the falling edge of clk.
REQ-005 SHALL have port rx, input, 1 bit: UART line, asynchronous to clk, idle high.
REQ-006 SHALL have port go, input, 1 bit: consumer enables reception when high and acknowledges a byte by driving go low.
REQ-007 SHALL have port data, output, 8 bits: received byte, LSB first on the line.
REQ-008 SHALL have port dr, output, 1 bit: data ready; high while data holds an unacknowledged byte.
REQ-009 SHALL have port ferr, output, 1 bit: framing error; stop bit sampled low for the byte now in data.

Function
REQ-010 SHALL define BIT_TIME = ClockFrequencyHz / BaudRate (integer division) and HALF_BIT = BIT_TIME / 2; the counter width SHALL be max(1, clog2(BIT_TIME)).
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use only the synchronized value rx_s and its previous value rx_p.
REQ-012 SHALL implement the states Idle, StartBit, DataBits, StopBit, and WaitForGoLow.
REQ-013 Idle: when go=1 and a falling edge is seen (rx_p=1, rx_s=0), the block SHALL load the counter with HALF_BIT-1 and go to StartBit; otherwise it SHALL stay in Idle.
REQ-014 StartBit: the counter SHALL decrement each cycle; at 0, if rx_s=0 the block SHALL load BIT_TIME-1, clear the bit index, and go to DataBits; if rx_s=1 (glitch) it SHALL return to Idle with no output change.
REQ-015 DataBits: the counter SHALL decrement; at 0 the block SHALL write rx_s into shift bit [index] and reload BIT_TIME-1; after the sample at index 7 it SHALL go to StopBit.
REQ-016 StopBit: the counter SHALL decrement; at 0 the block SHALL copy the shift register to data, set ferr to the inverse of rx_s, set dr=1, and go to WaitForGoLow, all in the same cycle.
REQ-017 WaitForGoLow: rx SHALL be ignored; when go=0 the block SHALL clear dr and go to Idle; data and ferr SHALL hold until the next StopBit completes.
REQ-018 go SHALL be examined only in Idle and WaitForGoLow; dropping go mid-frame SHALL NOT abort reception.
REQ-019 A line held low at entry to Idle SHALL NOT start a frame; a new high-to-low transition is required.
REQ-020 Each sample SHALL fall at the bit centre ±1 clk plus 2 synchronizer cycles; no oversampling or majority vote is applied.
REQ-021 Bytes arriving while dr=1 SHALL be lost; the block provides no buffering and no overrun flag.

Reset
REQ-022 When rst_n=0, the block SHALL force state=Idle, counter=0, bit index=0, shift register=0, data=0, dr=0, ferr=0, and both synchronizer flops=1, regardless of clk.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte; after release, a new falling edge is required before reception starts.

Verification (ClockFrequencyHz=20, BaudRate=2, so BIT_TIME=10 and HALF_BIT=5)
REQ-024 go=1, rx sends 0xA5 with a valid stop bit (10 clk per bit) -> dr rises within the stop bit, data=0xA5, ferr=0; go=0 -> dr=0 on the next falling edge.
REQ-025 go=1, rx low pulse of 3 clk then high -> the block returns to Idle, dr stays 0, and data is unchanged.
REQ-026 go=1, rx sends 0x3C with the stop bit low -> dr=1, data=0x3C, ferr=1.
REQ-027 Receive 0x11, keep go=1, then send 0x22 -> data stays 0x11; after go=0, go=1, and a resend of 0x22 -> data=0x22.
REQ-028 rst_n pulsed low during data bit 4 of 0xFF -> outputs are 0 immediately; the remaining bits produce no dr; a following 0x5A is received correctly.
REQ-029 go=0 throughout a frame of 0x81 -> the block stays in Idle and dr stays 0.
